// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 16-bit stack CPU: IDLE -> FETCH -> EXEC, one commit per retired word.
// Optional data-stack guard (FAULT state) is compiled in with `define SEQ_STACK_GUARD_EN.
module instr_sequencer #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 18,
  parameter int STACK_DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_run,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_data,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_instr_valid,
  input  logic                   i_stall,
  input  logic                   i_jump_taken,
  input  logic [PC_WIDTH-1:0]    i_jump_target,
  input  logic                   i_sp_push,
  input  logic                   i_sp_pop,
  output logic                   o_commit,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [15:0]            o_retired,
  output logic                   o_busy,
  output logic                   o_fault
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FAULT} state_e;

  state_e                   state_q;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q;
  logic [15:0]              retired_q;
  logic                     exec_done, guard_trip;

  assign exec_done = (state_q == S_EXEC) && !i_stall;
  assign pc_d      = i_jump_taken ? i_jump_target : pc_q + PC_WIDTH'(1);

`ifdef SEQ_STACK_GUARD_EN
  logic [DW-1:0] depth_q;
  logic          fault_q;
  logic          push_only, pop_only;

  assign push_only  = i_sp_push & ~i_sp_pop;
  assign pop_only   = i_sp_pop & ~i_sp_push;
  // An over/underflowing instruction never retires; it parks the sequencer in FAULT.
  assign guard_trip = exec_done &&
                      ((push_only && depth_q == DW'(STACK_DEPTH)) || (pop_only && depth_q == '0));
  assign o_fault    = fault_q;
`else
  logic [DW-1:0] unused_depth;
  logic          unused_sp;

  assign unused_depth = '0;
  assign unused_sp    = i_sp_push ^ i_sp_pop;
  assign guard_trip   = 1'b0;
  assign o_fault      = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
`ifdef SEQ_STACK_GUARD_EN
      depth_q   <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE:  if (i_run) state_q <= S_FETCH;
        S_FETCH: if (i_imem_ack) begin
          instr_q <= i_imem_data;
          state_q <= S_EXEC;
        end
        S_EXEC: if (exec_done) begin
          if (guard_trip) begin
            state_q <= S_FAULT;
`ifdef SEQ_STACK_GUARD_EN
            fault_q <= 1'b1;
`endif
          end else begin
            pc_q      <= pc_d;
            retired_q <= retired_q + 16'd1;
            state_q   <= i_run ? S_FETCH : S_IDLE;
`ifdef SEQ_STACK_GUARD_EN
            if (push_only)     depth_q <= depth_q + DW'(1);
            else if (pop_only) depth_q <= depth_q - DW'(1);
`endif
          end
        end
        default: state_q <= S_FAULT;
      endcase
    end
  end

  assign o_imem_req    = (state_q == S_FETCH);
  assign o_imem_addr   = pc_q;
  assign o_instr       = instr_q;
  assign o_instr_valid = (state_q == S_EXEC);
  assign o_commit      = exec_done && !guard_trip;
  assign o_pc          = pc_q;
  assign o_retired     = retired_q;
  assign o_busy        = (state_q != S_IDLE);
endmodule
